// File: rtl/spi_memory_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_memory_bank_pkg                                          |
// | Description : Shared constants, state encoding and frame builder for the   |
// |               SPI-backed memory bank.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spi_memory_bank_pkg;

  // 23LC512-style opcodes
  localparam logic [7:0] c_spi_cmd_read  = 8'h03;
  localparam logic [7:0] c_spi_cmd_write = 8'h02;

  // One word access is a fixed 40-bit frame: 8 command, 16 address, 16 data
  localparam int c_frame_bits     = 40;
  localparam int c_data_first_bit = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CS_HOLD = 2'd2
  } state_t;

  // Word address becomes a big-endian byte address (high byte at the even
  // address), so the byte address LSB and MSB are always zero. Reads send
  // zeros in the data phase.
  function automatic logic [c_frame_bits-1:0] build_frame(
    input logic        we,
    input logic [13:0] addr,
    input logic [15:0] data
  );
    return {(we ? c_spi_cmd_write : c_spi_cmd_read),
            1'b0, addr, 1'b0,
            (we ? data : 16'h0000)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_memory_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_memory_bank_if                                           |
// | Description : Word-access bus between memory_bus and the SPI memory bank.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface spi_memory_bank_if;
  logic [13:0] address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        start;
  logic        write_enable;
  logic        ready;

  // memory_bus side issues requests
  modport master (
    output address, data_in, start, write_enable,
    input  data_out, ready
  );

  // bank side serves them
  modport slave (
    input  address, data_in, start, write_enable,
    output data_out, ready
  );
endinterface
`default_nettype wire

// File: rtl/spi_memory_bank_clock_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_memory_bank_clock_gen                                    |
// | Description : SPI mode-0 serial clock generator. Free-running while        |
// |               enabled; each bit is 2*CLK_DIV clk cycles, low half first.   |
// |               Provides rise/fall/bit_done strobes aligned with the edge    |
// |               that changes the spi_clk level.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_memory_bank_clock_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_spi_clk,
  output logic o_rise,
  output logic o_fall,
  output logic o_bit_done
);
  localparam int c_div_w = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_rise_at = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_end_at  = c_div_w'(2 * CLK_DIV - 1);

  logic [c_div_w-1:0] r_div;
  logic               r_spi_clk;
  logic               w_at_rise;
  logic               w_at_end;

  // Strobes are true during the cycle whose closing edge changes spi_clk
  assign w_at_rise = i_enable && (r_div == c_rise_at);
  assign w_at_end  = i_enable && (r_div == c_end_at);

  // Divider phase and the registered spi_clk level; disabled means idle-low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div     <= '0;
      r_spi_clk <= 1'b0;
    end else if (!i_enable) begin
      r_div     <= '0;
      r_spi_clk <= 1'b0;
    end else begin
      r_div <= w_at_end ? '0 : r_div + 1'b1;
      if (w_at_rise) begin
        r_spi_clk <= 1'b1;
      end else if (w_at_end) begin
        r_spi_clk <= 1'b0;
      end
    end
  end

  assign o_spi_clk  = r_spi_clk;
  assign o_rise     = w_at_rise;
  assign o_fall     = w_at_end;
  assign o_bit_done = w_at_end;
endmodule
`default_nettype wire

// File: rtl/spi_memory_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_memory_bank                                              |
// | Description : Serves one 16 KiW bank from an external SPI SRAM/EEPROM.     |
// |               Each word access becomes one 40-bit mode-0 SPI frame.        |
// |               ready is low for exactly 1+82*CLK_DIV cycles per access.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_memory_bank
  import spi_memory_bank_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  spi_memory_bank_if.slave bus,
  output logic             spi_cs,
  output logic             spi_clk,
  output logic             spi_do,
  input  logic             spi_di
);
  // CS_HOLD counts 0..2*CLK_DIV, i.e. 2*CLK_DIV+1 cycles of deselect before ready
  localparam int c_hold_w = $clog2(2 * CLK_DIV + 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(2 * CLK_DIV);
  localparam logic [5:0] c_last_bit   = 6'(c_frame_bits - 1);
  localparam logic [5:0] c_first_data = 6'(c_data_first_bit);

  state_t                  r_state;
  logic [c_frame_bits-1:0] r_shift;
  logic [5:0]              r_bit;
  logic [c_hold_w-1:0]     r_hold;
  logic [15:0]             r_rx;
  logic [15:0]             r_data_out;
  logic                    r_we;
  logic                    r_ready;
  logic                    r_cs;

  logic                    w_enable;
  logic                    w_rise;
  logic                    w_fall;
  logic                    w_bit_done;
  logic [c_frame_bits-1:0] w_frame;

  assign w_enable = (r_state == ST_SHIFT);
  assign w_frame  = build_frame(bus.write_enable, bus.address, bus.data_in);

  spi_memory_bank_clock_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clock_gen (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (w_enable),
    .o_spi_clk  (spi_clk),
    .o_rise     (w_rise),
    .o_fall     (w_fall),
    .o_bit_done (w_bit_done)
  );

  // Transaction FSM: accept, shift the frame out MSB first, hold CS high, return
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit      <= '0;
      r_hold     <= '0;
      r_rx       <= '0;
      r_data_out <= '0;
      r_we       <= 1'b0;
      r_ready    <= 1'b1;
      r_cs       <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            // spi_do is the shift register MSB, so bit 0 is on the wire
            // from the first cycle after accept
            r_shift <= w_frame;
            r_we    <= bus.write_enable;
            r_bit   <= '0;
            r_cs    <= 1'b0;
            r_ready <= 1'b0;
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // MISO is sampled on the edge that raises spi_clk; only the data
          // phase of a read is kept
          if (w_rise && !r_we && (r_bit >= c_first_data)) begin
            r_rx <= {r_rx[14:0], spi_di};
          end
          // Next MOSI bit goes out on the falling edge; after the last bit the
          // register has drained to zero, leaving spi_do low
          if (w_fall) begin
            r_shift <= {r_shift[c_frame_bits-2:0], 1'b0};
          end
          if (w_bit_done) begin
            if (r_bit == c_last_bit) begin
              r_cs    <= 1'b1;
              r_hold  <= '0;
              r_state <= ST_CS_HOLD;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end

        ST_CS_HOLD: begin
          if (r_hold == c_hold_last) begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
            if (!r_we) begin
              r_data_out <= r_rx;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi_cs       = r_cs;
  assign spi_do       = r_shift[c_frame_bits-1];
  assign bus.ready    = r_ready;
  assign bus.data_out = r_data_out;
endmodule
`default_nettype wire
